// File: rtl/csr_unit.sv
// Machine-mode CSR file for a single-hart core: CSR read/modify/write, trap entry/MRET
// redirect sequencing, and the 64-bit cycle/instret counters.
module csr_unit #(
    parameter logic [31:0]       MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0]       HART_ID     = 32'h0000_0000,
    localparam int unsigned      DATA_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              csr_req_i,
    input  logic [1:0]        csr_op_i,
    input  logic [11:0]       csr_addr_i,
    input  logic [DATA_W-1:0] csr_wdata_i,
    output logic [DATA_W-1:0] csr_rdata_o,
    output logic              csr_ack_o,
    output logic              csr_illegal_o,
    input  logic              trap_i,
    input  logic [DATA_W-1:0] trap_cause_i,
    input  logic [DATA_W-1:0] trap_pc_i,
    input  logic              mret_i,
    input  logic              retire_i,
    output logic              redirect_valid_o,
    output logic [DATA_W-1:0] redirect_pc_o,
    output logic              mie_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [DATA_W-1:0] MISA_VAL = 32'h4000_1100;
    localparam logic [DATA_W-1:0] ALIGN_MASK = ~32'h0000_0003;

    typedef enum logic {
        S_IDLE,
        S_REDIRECT
    } state_e;

    state_e            state_q, state_d;
    logic              mie_q, mie_d, mpie_q, mpie_d;
    logic [DATA_W-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [DATA_W-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
    logic [DATA_W-1:0] redir_pc_q, redir_pc_d;
    logic [63:0]       mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic              take_trap, take_mret, ack_c, do_write;
    logic              is_write, known, read_only, illegal;
    logic [DATA_W-1:0] old_val, new_val;

    // Address decode, legality and the read-modify-write operand
    always_comb begin
        is_write  = (csr_op_i == 2'b01) || ((csr_op_i[1] == 1'b1) && (csr_wdata_i != '0));
        known     = 1'b1;
        read_only = 1'b0;
        old_val   = '0;
        case (csr_addr_i)
            ADDR_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            ADDR_MISA:      begin old_val = MISA_VAL; read_only = 1'b1; end
            ADDR_MTVEC:     old_val = mtvec_q;
            ADDR_MSCRATCH:  old_val = mscratch_q;
            ADDR_MEPC:      old_val = mepc_q;
            ADDR_MCAUSE:    old_val = mcause_q;
            ADDR_MCYCLE:    old_val = mcycle_q[31:0];
            ADDR_MINSTRET:  old_val = minstret_q[31:0];
            ADDR_MCYCLEH:   old_val = mcycle_q[63:32];
            ADDR_MINSTRETH: old_val = minstret_q[63:32];
            ADDR_MHARTID:   begin old_val = HART_ID; read_only = 1'b1; end
            default:        known = 1'b0;
        endcase
        illegal = !known || (is_write && (read_only || (csr_addr_i[11:10] == 2'b11)));
        csr_rdata_o = illegal ? '0 : old_val;
        case (csr_op_i)
            2'b01:   new_val = csr_wdata_i;
            2'b10:   new_val = old_val | csr_wdata_i;
            2'b11:   new_val = old_val & ~csr_wdata_i;
            default: new_val = old_val;
        endcase
    end

    // Sequencer: trap beats MRET beats CSR access; REDIRECT blocks everything for one cycle
    always_comb begin
        state_d   = state_q;
        ack_c     = 1'b0;
        take_trap = 1'b0;
        take_mret = 1'b0;
        case (state_q)
            S_IDLE: begin
                ack_c = csr_req_i && !trap_i && !mret_i;
                if (trap_i) begin
                    take_trap = 1'b1;
                    state_d   = S_REDIRECT;
                end else if (mret_i) begin
                    take_mret = 1'b1;
                    state_d   = S_REDIRECT;
                end
            end
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    assign csr_ack_o        = ack_c && !rst_i;
    assign csr_illegal_o    = csr_ack_o && illegal;
    assign do_write         = csr_ack_o && !illegal && is_write;
    assign redirect_valid_o = (state_q == S_REDIRECT);
    assign redirect_pc_o    = (state_q == S_REDIRECT) ? redir_pc_q : '0;
    assign mie_o            = mie_q;

    // Next-state values of the architectural registers
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        redir_pc_d = redir_pc_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = retire_i ? (minstret_q + 64'd1) : minstret_q;
        if (take_trap) begin
            mepc_d     = trap_pc_i & ALIGN_MASK;
            mcause_d   = trap_cause_i;
            mpie_d     = mie_q;
            mie_d      = 1'b0;
            redir_pc_d = mtvec_q;
        end else if (take_mret) begin
            mie_d      = mpie_q;
            mpie_d     = 1'b1;
            redir_pc_d = mepc_q;
        end
        if (do_write) begin
            case (csr_addr_i)
                ADDR_MSTATUS:   begin mie_d = new_val[3]; mpie_d = new_val[7]; end
                ADDR_MTVEC:     mtvec_d = new_val & ALIGN_MASK;
                ADDR_MSCRATCH:  mscratch_d = new_val;
                ADDR_MEPC:      mepc_d = new_val & ALIGN_MASK;
                ADDR_MCAUSE:    mcause_d = new_val;
                ADDR_MCYCLE:    mcycle_d = {mcycle_q[63:32], new_val};
                ADDR_MCYCLEH:   mcycle_d = {new_val, mcycle_q[31:0]};
                ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
                ADDR_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
                default:        ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            redir_pc_q <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            state_q    <= state_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            redir_pc_q <= redir_pc_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: stimulus queues expected acks/redirects, a negedge
// monitor pops and compares them as the DUT presents them.
module tb_csr_unit;

    localparam logic [31:0] HART = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        csr_req_i = 1'b0;
    logic [1:0]  csr_op_i = 2'b00;
    logic [11:0] csr_addr_i = 12'h000;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] csr_rdata_o;
    logic        csr_ack_o, csr_illegal_o;
    logic        trap_i = 1'b0;
    logic [31:0] trap_cause_i = '0;
    logic [31:0] trap_pc_i = '0;
    logic        mret_i = 1'b0;
    logic        retire_i = 1'b0;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        mie_o;

    always #5 clk = ~clk;

    csr_unit #(.MTVEC_RESET(32'h0000_0100), .HART_ID(HART)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .csr_req_i(csr_req_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_ack_o(csr_ack_o),
        .csr_illegal_o(csr_illegal_o), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
        .trap_pc_i(trap_pc_i), .mret_i(mret_i), .retire_i(retire_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .mie_o(mie_o)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        ill;
        logic        care;
        int          cyc;
        string       name;
    } ack_exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        mie;
        string       name;
    } rd_exp_t;

    ack_exp_t ack_q[$];
    rd_exp_t  rd_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack / redirect must match the oldest queued expectation
    always @(negedge clk) begin
        if (csr_ack_o) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack addr %h expected no ack", csr_addr_i);
            end else begin
                ack_exp_t e;
                e = ack_q.pop_front();
                if (e.care) chk({e.name, "_rdata"}, csr_rdata_o, e.rdata);
                chk({e.name, "_illegal"}, 32'(csr_illegal_o), 32'(e.ill));
                if (e.cyc >= 0) chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
        if (redirect_valid_o) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc_o);
            end else begin
                rd_exp_t r;
                r = rd_q.pop_front();
                chk({r.name, "_pc"}, redirect_pc_o, r.pc);
                chk({r.name, "_mie"}, 32'(mie_o), 32'(r.mie));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_ill, input logic care,
                          input string name);
        logic acked;
        ack_q.push_back('{exp_rd, exp_ill, care, -1, name});
        csr_req_i   = 1'b1;
        csr_op_i    = op;
        csr_addr_i  = addr;
        csr_wdata_i = wd;
        acked = 1'b0;
        for (int i = 0; i < 16 && !acked; i++) begin
            @(negedge clk);
            acked = csr_ack_o;
            tick();
        end
        csr_req_i = 1'b0;
        chk({name, "_acked"}, 32'(acked), 32'd1);
    endtask

    task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc,
                           input logic [31:0] exp_pc, input logic exp_mie, input string name);
        rd_q.push_back('{exp_pc, exp_mie, name});
        trap_i = 1'b1;
        trap_cause_i = cause;
        trap_pc_i = pc;
        tick();
        trap_i = 1'b0;
    endtask

    task automatic do_mret(input logic [31:0] exp_pc, input logic exp_mie, input string name);
        rd_q.push_back('{exp_pc, exp_mie, name});
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acked;
        repeat (2) tick();
        // Reset must override a trap and a write presented in the same cycle
        trap_i = 1'b1; trap_pc_i = 32'h0000_4000;
        csr_req_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h340; csr_wdata_i = 32'h1111_1111;
        tick();
        rst_i = 1'b0; trap_i = 1'b0; csr_req_i = 1'b0;
        @(negedge clk);
        chk("reset_redirect_valid", 32'(redirect_valid_o), 32'd0);
        chk("reset_redirect_pc", redirect_pc_o, 32'd0);
        chk("reset_mie", 32'(mie_o), 32'd0);
        tick();

        access(2'b00, 12'h300, 0, 32'h0000_1800, 0, 1, "rst_mstatus");
        access(2'b00, 12'h305, 0, 32'h0000_0100, 0, 1, "rst_mtvec");
        access(2'b00, 12'hF14, 0, HART,          0, 1, "rst_mhartid");
        access(2'b00, 12'h340, 0, 32'h0,         0, 1, "rst_mscratch");
        access(2'b00, 12'h341, 0, 32'h0,         0, 1, "rst_mepc");
        access(2'b00, 12'h301, 0, 32'h4000_1100, 0, 1, "misa");

        access(2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0,         0, 1, "scratch_rw");
        access(2'b11, 12'h340, 32'h0000_00FF, 32'hDEAD_BEEF, 0, 1, "scratch_rc");
        access(2'b00, 12'h340, 0,             32'hDEAD_BE00, 0, 1, "scratch_rd");

        access(2'b01, 12'h300, 32'h0000_0008, 32'h0000_1800, 0, 1, "mstatus_set_mie");
        access(2'b00, 12'h300, 0,             32'h0000_1808, 0, 1, "mstatus_mie1");
        do_trap(32'd2, 32'h0000_2003, 32'h0000_0100, 1'b0, "trap1");
        access(2'b00, 12'h341, 0, 32'h0000_2000, 0, 1, "trap1_mepc");
        access(2'b00, 12'h342, 0, 32'h0000_0002, 0, 1, "trap1_mcause");
        access(2'b00, 12'h300, 0, 32'h0000_1880, 0, 1, "trap1_mstatus");
        do_mret(32'h0000_2000, 1'b1, "mret1");
        access(2'b00, 12'h300, 0, 32'h0000_1888, 0, 1, "mret1_mstatus");

        // Trap, MRET and a CSR read in one cycle: trap wins, read is acked two cycles later
        ack_q.push_back('{32'hDEAD_BE00, 1'b0, 1'b1, cyc + 2, "simul_ack"});
        rd_q.push_back('{32'h0000_0100, 1'b0, "simul_trap"});
        trap_i = 1'b1; mret_i = 1'b1; trap_cause_i = 32'd7; trap_pc_i = 32'h0000_3000;
        csr_req_i = 1'b1; csr_op_i = 2'b00; csr_addr_i = 12'h340; csr_wdata_i = 0;
        acked = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            acked = csr_ack_o;
            tick();
            trap_i = 1'b0;
            mret_i = 1'b0;
        end
        csr_req_i = 1'b0;
        chk("simul_acked", 32'(acked), 32'd1);
        access(2'b00, 12'h341, 0, 32'h0000_3000, 0, 1, "simul_mepc");
        access(2'b00, 12'h342, 0, 32'h0000_0007, 0, 1, "simul_mcause");
        access(2'b00, 12'h300, 0, 32'h0000_1880, 0, 1, "simul_mstatus");

        access(2'b01, 12'hB00, 32'hFFFF_FFFF, 32'h0, 0, 0, "mcycle_wr");
        access(2'b01, 12'hB80, 32'hFFFF_FFFF, 32'h0, 0, 1, "mcycleh_wr");
        tick();
        access(2'b00, 12'hB00, 0, 32'h0, 0, 1, "mcycle_wrap");
        access(2'b00, 12'hB80, 0, 32'h0, 0, 1, "mcycleh_wrap");

        access(2'b01, 12'hB02, 32'd5, 32'd0, 0, 1, "minstret_wr");
        retire_i = 1'b1;
        repeat (3) tick();
        retire_i = 1'b0;
        access(2'b00, 12'hB02, 0, 32'd8, 0, 1, "minstret_rd");
        access(2'b00, 12'hB82, 0, 32'd0, 0, 1, "minstreth_rd");

        access(2'b01, 12'h301, 32'h0000_1234, 32'h0, 1, 1, "misa_wr_illegal");
        access(2'b00, 12'h7C0, 0,             32'h0, 1, 1, "unimpl_illegal");
        access(2'b00, 12'h301, 0, 32'h4000_1100, 0, 1, "misa_unchanged");
        access(2'b01, 12'hF14, 32'h1, 32'h0, 1, 1, "mhartid_wr_illegal");
        access(2'b10, 12'hF14, 32'h0, HART,  0, 1, "mhartid_rs0_legal");

        access(2'b10, 12'h340, 32'h0000_000F, 32'hDEAD_BE00, 0, 1, "scratch_rs");
        access(2'b00, 12'h340, 0,             32'hDEAD_BE0F, 0, 1, "scratch_rs_rd");

        access(2'b01, 12'h305, 32'h0000_0207, 32'h0000_0100, 0, 1, "mtvec_wr");
        access(2'b00, 12'h305, 0,             32'h0000_0204, 0, 1, "mtvec_align");
        do_trap(32'd3, 32'h0000_5000, 32'h0000_0204, 1'b0, "trap2");

        repeat (3) tick();
        chk("ack_queue_empty", 32'(ack_q.size()), 32'd0);
        chk("redirect_queue_empty", 32'(rd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have parameter MTVEC_RESET, 32'h0000_0100, mtvec reset value (bits 1:0 forced 00).
REQ-002 SHALL have parameter HART_ID, 0, value read from mhartid.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port csr_req_i  in  1  CSR access request from the writeback stage.
REQ-007 SHALL have port csr_op_i  in  2  access type: 01 RW (write), 10 RS (set bits), 11 RC (clear bits), 00 read-only.
REQ-008 SHALL have port csr_addr_i  in  12  CSR address.
REQ-009 SHALL have port csr_wdata_i  in  DATA_W  write operand.
REQ-010 SHALL have port csr_rdata_o  out  DATA_W  pre-write value of the addressed CSR (combinational).
REQ-011 SHALL have port csr_ack_o  out  1  request accepted this cycle.
REQ-012 SHALL have port csr_illegal_o  out  1  accepted request is illegal; valid only with csr_ack_o.
REQ-013 SHALL have port trap_i  in  1  exception commit from writeback.
REQ-014 SHALL have port trap_cause_i  in  DATA_W  mcause value to record.
REQ-015 SHALL have port trap_pc_i  in  DATA_W  PC of the faulting instruction.
REQ-016 SHALL have port mret_i  in  1  MRET commit.
REQ-017 SHALL have port retire_i  in  1  one instruction retired this cycle.
REQ-018 SHALL have port redirect_valid_o  out  1  fetch redirect, one-cycle pulse.
REQ-019 SHALL have port redirect_pc_o  out  DATA_W  redirect target.
REQ-020 SHALL have port mie_o  out  1  mstatus.MIE.

Function
REQ-021 SHALL implement: mstatus 0x300, misa 0x301 (RO, 32'h4000_1100), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mhartid 0xF14 (RO).
REQ-022 SHALL keep a two-state FSM: IDLE, REDIRECT; REDIRECT lasts exactly one cycle, then IDLE.
REQ-023 SHALL, in IDLE, set csr_ack_o = csr_req_i & ~trap_i & ~mret_i; in REDIRECT csr_ack_o = 0 (requester holds csr_req_i until ack).
REQ-024 SHALL compute new value = wdata (RW), old|wdata (RS), old&~wdata (RC), applied at the ack edge; csr_rdata_o is the old value.
REQ-025 SHALL treat RS/RC with csr_wdata_i==0 and op 00 as non-writes.
REQ-026 SHALL flag csr_illegal_o for an unimplemented address, or a write to address[11:10]==2'b11; illegal access changes no state, csr_rdata_o = 0.
REQ-027 SHALL make writable only mstatus bits 3 (MIE) and 7 (MPIE); mstatus bits 12:11 read 2'b11, others 0.
REQ-028 SHALL force mtvec[1:0] and mepc[1:0] to 00 on every write.
REQ-029 SHALL, on trap_i in IDLE: mepc <= trap_pc_i & ~3, mcause <= trap_cause_i, MPIE <= MIE, MIE <= 0, enter REDIRECT with redirect_pc_o = mtvec.
REQ-030 SHALL, on mret_i in IDLE without trap_i: MIE <= MPIE, MPIE <= 1, enter REDIRECT with redirect_pc_o = mepc.
REQ-031 SHALL register the redirect target at the trap/mret edge and assert redirect_valid_o only in REDIRECT; redirect_pc_o = 0 otherwise.
REQ-032 SHALL give priority trap_i > mret_i > CSR access in the same cycle; lower-priority events are dropped (not acked).
REQ-033 SHALL ignore trap_i and mret_i while in REDIRECT.
REQ-034 SHALL increment the 64-bit mcycle every cycle not in reset and minstret when retire_i, both wrapping 2^64-1 -> 0.
REQ-035 SHALL, on a software write to a counter half, load that half with the written value and suppress that counter's increment that cycle; the other half holds.
REQ-036 SHALL count retire_i regardless of FSM state.

Reset
REQ-037 SHALL on rst_i: state IDLE, mstatus MIE=MPIE=0, mtvec=MTVEC_RESET, mscratch=mepc=mcause=0, counters 0, redirect_valid_o=0, redirect_pc_o=0, csr_ack_o=0; rst_i overrides trap/mret/write in the same cycle.

Verification
REQ-038 SHALL check reset: after rst_i, read 0x300 -> 32'h0000_1800, 0x305 -> 32'h0000_0100, 0xF14 -> HART_ID.
REQ-039 SHALL check RW mscratch 32'hDEAD_BEEF then RC 32'h0000_00FF -> second rdata 32'hDEAD_BEEF, final read 32'hDEAD_BE00.
REQ-040 SHALL check trap with MIE=1, cause 2, pc 32'h0000_2003 -> next cycle redirect_valid_o=1, pc 32'h0000_0100; mepc 32'h0000_2000, MIE=0, MPIE=1; then mret -> redirect to 32'h0000_2000, MIE=1.
REQ-041 SHALL check simultaneous trap_i, mret_i, csr_req_i -> trap taken, csr_ack_o=0, request acked two cycles later.
REQ-042 SHALL check RW 32'hFFFF_FFFF to mcycle and mcycleh -> read 0 from both halves two cycles later (wrap).
REQ-043 SHALL check RW to 0x301 and read of 0x7C0 -> csr_illegal_o=1, no state change.
